// File: rtl/painel_scroll_controller.sv
// 5x7 LED panel sequencer: loads a column message, scans rows with a
// programmable dwell and scrolls a 7-column window across message + blank gap.
module painel_scroll_controller #(
  parameter int MSG_DEPTH       = 32,
  parameter int SCAN_DIV        = 1000,
  parameter int FRAMES_PER_STEP = 20
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       wr_valid,
  input  logic [4:0] wr_data,
  input  logic       wr_last,
  output logic       wr_ready,
  output logic [4:0] ROW,
  output logic [6:0] COL,
  output logic       frame_done,
  output logic       step,
  output logic       busy
);
  localparam int LW = $clog2(MSG_DEPTH + 8);
  localparam int AW = $clog2(MSG_DEPTH);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   len_q, len_d, off_q, off_d, n_q, n_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [2:0]      row_q, row_d;
  logic [FW-1:0]   frm_q, frm_d;
  logic            frame_d, step_d, xfer;
  logic [6:0]      col_d;
  logic [4:0]      msg_buf [MSG_DEPTH];

  assign wr_ready = (state_q == S_LOAD) && (len_q < LW'(MSG_DEPTH));
  assign n_q      = len_q + LW'(7);
  assign n_d      = len_d + LW'(7);

  always_ff @(posedge CLK)
    if (xfer) msg_buf[len_q[AW-1:0]] <= wr_data;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    off_d   = off_q;
    presc_d = presc_q;
    row_d   = row_q;
    frm_d   = frm_q;
    frame_d = 1'b0;
    step_d  = 1'b0;
    xfer    = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LOAD;
        len_d   = '0;
      end
      S_LOAD: if (wr_valid && wr_ready) begin
        xfer  = 1'b1;
        len_d = len_q + 1'b1;
        if (wr_last || len_d == LW'(MSG_DEPTH)) begin
          state_d = S_RUN;
          off_d   = '0;
          presc_d = '0;
          row_d   = '0;
          frm_d   = '0;
        end
      end
      S_RUN: begin
        if (presc_q == PW'(SCAN_DIV - 1)) begin
          presc_d = '0;
          if (row_q == 3'd4) begin
            row_d   = '0;
            frame_d = 1'b1;
            if (frm_q == FW'(FRAMES_PER_STEP - 1)) begin
              frm_d = '0;
              if (!pause) begin
                step_d = 1'b1;
                off_d  = (off_q == n_q - 1'b1) ? '0 : off_q + 1'b1;
              end
            end else begin
              frm_d = frm_q + 1'b1;
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (stop) begin
      state_d = S_IDLE;
      xfer    = 1'b0;
      frame_d = 1'b0;
      step_d  = 1'b0;
      len_d   = len_q;
    end
  end

  // Window is built from next-cycle offset/row so ROW and COL change together;
  // the column being written this cycle is bypassed for the first RUN cycle.
  always_comb begin
    logic [LW:0] idx;
    logic [4:0]  pat;
    col_d = '0;
    idx   = '0;
    pat   = '0;
    for (int k = 0; k < 7; k++) begin
      idx = {1'b0, off_d} + (LW+1)'(k);
      if (idx >= {1'b0, n_d}) idx = idx - {1'b0, n_d};
      pat = (xfer && idx[LW-1:0] == len_q) ? wr_data : msg_buf[idx[AW-1:0]];
      if (idx < {1'b0, len_d}) col_d[k] = pat[row_d];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      off_q      <= '0;
      presc_q    <= '0;
      row_q      <= '0;
      frm_q      <= '0;
      ROW        <= '0;
      COL        <= '0;
      frame_done <= 1'b0;
      step       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      off_q      <= off_d;
      presc_q    <= presc_d;
      row_q      <= row_d;
      frm_q      <= frm_d;
      frame_done <= frame_d;
      step       <= step_d;
      busy       <= (state_d != S_IDLE);
      ROW        <= (state_d == S_RUN) ? (5'b00001 << row_d) : 5'b0;
      COL        <= (state_d == S_RUN) ? col_d : 7'b0;
    end
  end
endmodule

// File: tb/tb_painel_scroll_controller.sv
// Directed bench for the panel scroll controller (MSG_DEPTH=8, SCAN_DIV=4,
// FRAMES_PER_STEP=2). Inputs change and outputs are sampled on negedge.
module tb_painel_scroll_controller;
  logic       CLK = 1'b0, RST_N = 1'b0;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0;
  logic       wr_valid = 1'b0, wr_last = 1'b0;
  logic [4:0] wr_data = 5'h0;
  logic       wr_ready, frame_done, step, busy;
  logic [4:0] ROW;
  logic [6:0] COL;
  int passed = 0, total = 0;
  logic [4:0] pat [8];

  painel_scroll_controller #(.MSG_DEPTH(8), .SCAN_DIV(4), .FRAMES_PER_STEP(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .stop(stop), .pause(pause),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
    .ROW(ROW), .COL(COL), .frame_done(frame_done), .step(step), .busy(busy));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    pat = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h03, 5'h05, 5'h06};
    cyc(2);
    chk("rst_row", ROW, 0);   chk("rst_col", COL, 0);   chk("rst_busy", busy, 0);
    chk("rst_rdy", wr_ready, 0); chk("rst_fd", frame_done, 0); chk("rst_step", step, 0);
    RST_N = 1'b1;
    cyc(1); start = 1'b1;
    cyc(1); start = 1'b0;
    chk("load_rdy", wr_ready, 1); chk("load_busy", busy, 1); chk("load_row", ROW, 0);
    wr_valid = 1'b1; wr_data = 5'h1F; cyc(1);
    wr_data = 5'h01; cyc(1);
    chk("load_rdy2", wr_ready, 1);
    wr_data = 5'h10; wr_last = 1'b1; cyc(1);
    wr_valid = 1'b0; wr_last = 1'b0;
    // t0: first RUN cycle, N=10
    chk("run_rdy", wr_ready, 0); chk("run_row0", ROW, 5'b00001);
    chk("run_col0", COL, 7'b0000011); chk("run_busy", busy, 1);
    cyc(4);  chk("t4_row", ROW, 5'b00010); chk("t4_col", COL, 7'b0000001);
    cyc(12); chk("t16_row", ROW, 5'b10000); chk("t16_col", COL, 7'b0000101);
    chk("t16_fd", frame_done, 0);
    cyc(4);  chk("t20_row", ROW, 5'b00001); chk("t20_fd", frame_done, 1); chk("t20_step", step, 0);
    cyc(1);  chk("t21_fd", frame_done, 0);
    cyc(19); chk("t40_step", step, 1); chk("t40_col", COL, 7'b0000001);
    cyc(1);  chk("t41_step", step, 0);
    cyc(15); chk("t56_row", ROW, 5'b10000); chk("t56_col_off1", COL, 7'b0000010);
    cyc(64); chk("t120_step", step, 1); chk("off3_l1", COL, 7'b0);
    cyc(16); chk("off3_l5", COL, 7'b0);
    cyc(224); chk("off9_col", COL, 7'b0000110); chk("off9_step", step, 1);
    cyc(40); chk("wrap_step", step, 1); chk("wrap_col", COL, 7'b0000011); chk("wrap_row", ROW, 5'b00001);
    cyc(1);  pause = 1'b1;
    cyc(39); chk("p440_fd", frame_done, 1); chk("p440_step", step, 0); chk("p440_col", COL, 7'b0000011);
    cyc(40); chk("p480_fd", frame_done, 1); chk("p480_step", step, 0); chk("p480_col", COL, 7'b0000011);
    cyc(1);  pause = 1'b0;
    cyc(39); chk("unp_step", step, 1); chk("unp_col", COL, 7'b0000001);
    cyc(5);  stop = 1'b1;
    cyc(1);  stop = 1'b0;
    chk("stop_row", ROW, 0); chk("stop_col", COL, 0); chk("stop_busy", busy, 0);
    // stop wins over start
    start = 1'b1; stop = 1'b1;
    cyc(1);  start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 0); chk("ss_rdy", wr_ready, 0);
    wr_valid = 1'b1; wr_data = 5'h1F;
    cyc(1);  chk("idle_wr_busy", busy, 0); chk("idle_wr_row", ROW, 0);
    wr_valid = 1'b0;
    // fill to MSG_DEPTH without wr_last, N=15
    start = 1'b1;
    cyc(1);  start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_data = pat[i];
      if (i == 7) chk("full_rdy7", wr_ready, 1);
      cyc(1);
    end
    wr_data = 5'h1F;
    chk("full_rdy", wr_ready, 0); chk("full_row", ROW, 5'b00001); chk("full_col", COL, 7'b1100001);
    cyc(1);  wr_valid = 1'b0;
    chk("full_9th", COL, 7'b1100001);
    cyc(15); chk("full_l5_row", ROW, 5'b10000); chk("full_l5_col", COL, 7'b0010000);
    stop = 1'b1;
    cyc(1);  stop = 1'b0;
    // single-column message with wr_last, N=8
    start = 1'b1;
    cyc(1);  start = 1'b0;
    wr_valid = 1'b1; wr_data = 5'h15; wr_last = 1'b1;
    cyc(1);  wr_valid = 1'b0; wr_last = 1'b0;
    chk("one_row", ROW, 5'b00001); chk("one_col", COL, 7'b0000001);
    cyc(8);  chk("one_l3_row", ROW, 5'b00100); chk("one_l3_col", COL, 7'b0000001);
    // async reset mid-RUN, checked before any clock edge
    #2 RST_N = 1'b0;
    #1 chk("arst_row", ROW, 0); chk("arst_col", COL, 0); chk("arst_busy", busy, 0);
    cyc(1);  RST_N = 1'b1;
    cyc(2);  chk("post_rst_busy", busy, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
